instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
Sits directly downstream of the fetch unit's PC register. Takes the PC stream, issues requests to instruction memory through a req/gnt/rvalid interface, and queues returned instructions with their PCs in a DEPTH-entry in-order buffer. The buffer feeds decode through a valid/ready handshake. A flush on branch, JAL or JALR redirect discards all buffered and in-flight fetches.

Parameters:
DEPTH, 4, buffer entries; power of two, >=2
XLEN, 32, address/instruction width

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
pc_i  in  XLEN  fetch address from fetch unit
pc_valid_i  in  1  pc_i valid
pc_ready_o  out  1  fetch accepted this cycle; fetch unit may advance PC
flush_i  in  1  redirect; discard buffer and in-flight responses
imem_req_o  out  1  memory request
imem_addr_o  out  XLEN  {pc_i[XLEN-1:2],2'b00}
imem_gnt_i  in  1  request accepted
imem_rvalid_i  in  1  response valid; in order, >=1 cycle after gnt
imem_rdata_i  in  XLEN  instruction word
dec_valid_o  out  1  head instruction available
dec_instr_o  out  XLEN  head instruction
dec_pc_o  out  XLEN  head PC
dec_ready_i  in  1  decode consumes head
count_o  out  $clog2(DEPTH)+1  allocated entries (filled + pending)

Behaviour:
- Storage: per entry pc, instr, filled bit. Three pointers, each $clog2(DEPTH)+1 bits with wrap bit: wptr (allocate), fptr (fill), rptr (read). count_o = wptr-rptr. Pending = wptr-fptr.
- Reset (rst_i=1, any time, async): pointers, discard counter, filled bits = 0. Outputs then: dec_valid_o=0, dec_instr_o=0, dec_pc_o=0, imem_req_o=0, pc_ready_o=0, count_o=0. Reset mid-operation drops everything; the memory is reset on the same signal.
- Issue (combinational): imem_req_o = pc_valid_i & ~flush_i & (count_o<DEPTH). pc_ready_o = imem_req_o & imem_gnt_i.
- Allocate: on pc_ready_o, the entry at wptr gets pc=pc_i and filled=0; wptr++. No full-bypass: a pop in the same cycle does not free a slot for that cycle's request.
- Fill: on imem_rvalid_i with discard=0 and pending>0, the entry at fptr gets instr=imem_rdata_i and filled=1; fptr++. An rvalid with pending=0 and discard=0 is a protocol error: it is ignored and flagged by a bench assertion.
- Output: dec_valid_o = (count_o>0) & filled[rptr] & ~flush_i. dec_instr_o and dec_pc_o come from the rptr entry while valid, and are 0 otherwise. Pop on dec_valid_o & dec_ready_i: rptr++ and filled cleared.
- Latency: gnt in cycle N, rvalid in cycle M>N. dec_valid_o rises in M+1 when the buffer was empty. There is no combinational rdata-to-decode path.
- Flush (next edge): wptr=fptr=rptr=0 and all filled=0. discard = pending, minus 1 if a non-discarded rvalid arrives in the flush cycle. That same-cycle response is also dropped.
  - While discard>0, each rvalid decrements discard and the data is dropped.
  - New requests are allowed immediately after flush. Their responses are filled only after discard reaches 0, which in-order return guarantees.
  - Flush while discard>0 adds the new pending count to discard.
- Simultaneous events: allocate, fill and pop may all occur in the same cycle. count_o update is +alloc -pop.
- Full (count_o=DEPTH): imem_req_o=0 and pc_ready_o=0, so the fetch unit holds its PC.
- Empty, or head not filled: dec_valid_o=0.
- Pointer wrap: the wrap bit distinguishes full from empty. Entry index = pointer[$clog2(DEPTH)-1:0].

Test Plan:
1. Reset then steady stream: pc 0x0,0x4,0x8 with gnt=1 and 1-cycle rvalid, dec_ready=1. Required: dec outputs pc/instr pairs in order. First dec_valid_o two cycles after first gnt. count_o <=2.
2. Backpressure: dec_ready=0 with pc_valid held. Required: 4 grants, count_o=4, imem_req_o=0 from then on. Then dec_ready=1: one pop per cycle, and a new req is accepted only in the cycle after the first pop.
3. Flush with 2 in flight: grants at 0x10 and 0x14, flush, then req 0x100. Required: the two rvalids (0xAAAA0001, 0xAAAA0002) are dropped. Decode sees pc 0x100 with the third response as the first valid.
4. Flush coincident with rvalid and pop: dec_valid_o=0 in the flush cycle. Next cycle count_o=0 and discard = pending-1.
5. Async reset mid-stream: rst_i asserted between edges with 3 entries. Required: dec_valid_o, imem_req_o and count_o go to 0 immediately, without waiting for a clock.
6. Misaligned pc_i=0x103: imem_addr_o=0x100 and dec_pc_o=0x103.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//   Issues instruction-memory requests for the PC stream and queues the
//   returned instructions, with their PCs, in an in-order buffer. Decode
//   reads the buffer through a valid/ready handshake. A redirect (flush)
//   empties the buffer and drops every response that is still in flight.
//
// Ports
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   pc_i, pc_valid_i    fetch address and its valid from the fetch unit
//   pc_ready_o          fetch accepted this cycle (request granted)
//   flush_i             redirect: discard buffer and in-flight responses
//   imem_req_o/addr_o   memory request and word-aligned address
//   imem_gnt_i          memory accepted the request
//   imem_rvalid_i/rdata_i  in-order response, >=1 cycle after grant
//   dec_valid_o/instr_o/pc_o/ready_i  head entry towards decode
//   count_o             allocated entries (filled + pending)
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     pc_valid_i,
    output logic                     pc_ready_o,
    input  logic                     flush_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic                     imem_gnt_i,
    input  logic                     imem_rvalid_i,
    input  logic [XLEN-1:0]          imem_rdata_i,
    output logic                     dec_valid_o,
    output logic [XLEN-1:0]          dec_instr_o,
    output logic [XLEN-1:0]          dec_pc_o,
    input  logic                     dec_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    // Repeated flushes can stack several buffers' worth of in-flight
    // responses, so the discard counter is wider than a pointer.
    localparam int DW = PW + 3;

    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   fptr_q, fptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [DW-1:0]   discard_q, discard_d;
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];

    logic [PW-1:0]   count_s;
    logic [PW-1:0]   pending_s;
    logic [IW-1:0]   widx_s, fidx_s, ridx_s;
    logic            alloc_s;
    logic            fill_s;
    logic            pop_s;
    logic            rv_used_s;
    logic            head_ok_s;

    assign count_s   = wptr_q - rptr_q;
    assign pending_s = wptr_q - fptr_q;
    assign widx_s    = wptr_q[IW-1:0];
    assign fidx_s    = fptr_q[IW-1:0];
    assign ridx_s    = rptr_q[IW-1:0];
    assign count_o   = count_s;

    // Request / handshake / head-of-queue combinational outputs.
    always_comb begin
        imem_req_o  = pc_valid_i & ~flush_i & ~rst_i & (count_s < PW'(DEPTH));
        pc_ready_o  = imem_req_o & imem_gnt_i;
        imem_addr_o = {pc_i[XLEN-1:2], 2'b00};
        head_ok_s   = (count_s != '0) & filled_q[ridx_s];
        dec_valid_o = head_ok_s & ~flush_i & ~rst_i;
        if (dec_valid_o) begin
            dec_instr_o = instr_mem_q[ridx_s];
            dec_pc_o    = pc_mem_q[ridx_s];
        end else begin
            dec_instr_o = '0;
            dec_pc_o    = '0;
        end
    end

    // Event decode: allocation, fill and pop for this cycle.
    always_comb begin
        alloc_s   = pc_ready_o;
        pop_s     = dec_valid_o & dec_ready_i;
        // A response is accounted for if it is either being discarded or
        // matches a pending entry; an rvalid with neither is ignored.
        rv_used_s = imem_rvalid_i & ((discard_q != '0) | (pending_s != '0));
        fill_s    = imem_rvalid_i & ~flush_i & (discard_q == '0) & (pending_s != '0);
    end

    // Next-state logic for pointers, filled bits and the discard counter.
    always_comb begin
        wptr_d    = wptr_q;
        fptr_d    = fptr_q;
        rptr_d    = rptr_q;
        filled_d  = filled_q;
        discard_d = discard_q;
        if (flush_i) begin
            wptr_d    = '0;
            fptr_d    = '0;
            rptr_d    = '0;
            filled_d  = '0;
            // Everything still pending joins the discard count; a response
            // arriving in this very cycle settles one of those (or one
            // already being discarded) and is itself dropped.
            discard_d = discard_q + DW'(pending_s) - DW'(rv_used_s);
        end else begin
            if (alloc_s) begin
                wptr_d           = wptr_q + PW'(1);
                filled_d[widx_s] = 1'b0;
            end else begin
                wptr_d = wptr_q;
            end
            if (fill_s) begin
                fptr_d           = fptr_q + PW'(1);
                filled_d[fidx_s] = 1'b1;
            end else begin
                fptr_d = fptr_q;
            end
            if (pop_s) begin
                rptr_d           = rptr_q + PW'(1);
                filled_d[ridx_s] = 1'b0;
            end else begin
                rptr_d = rptr_q;
            end
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - DW'(1);
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q    <= '0;
            fptr_q    <= '0;
            rptr_q    <= '0;
            filled_q  <= '0;
            discard_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            fptr_q    <= fptr_d;
            rptr_q    <= rptr_d;
            filled_q  <= filled_d;
            discard_q <= discard_d;
        end
    end

    // Entry payload storage; validity is tracked by the filled bits and
    // pointers, so the payload itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (alloc_s) begin
            pc_mem_q[widx_s] <= pc_i;
        end
        if (fill_s) begin
            instr_mem_q[fidx_s] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_ready_i;
    logic [2:0]  count_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int outstanding = 0;

    instr_fetch_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .dec_valid_o  (dec_valid_o),
        .dec_instr_o  (dec_instr_o),
        .dec_pc_o     (dec_pc_o),
        .dec_ready_i  (dec_ready_i),
        .count_o      (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory-side protocol monitor: a response needs an outstanding grant.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= 0;
        end else begin
            assert (!(imem_rvalid_i && outstanding == 0)) else begin
                fails = fails + 1;
                $error("FAIL rvalid_without_request outstanding=%0d", outstanding);
            end
            outstanding <= outstanding + (pc_ready_o ? 1 : 0) - (imem_rvalid_i ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passes = passes + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic gnt,
                         input logic rv, input logic [31:0] rd,
                         input logic fl, input logic rdy);
        pc_valid_i    = pv;
        pc_i          = pc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        flush_i       = fl;
        dec_ready_i   = rdy;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        cyc();
        // Reset state: outputs held low even with a valid PC offered.
        chk("rst_req",       {31'd0, imem_req_o},  32'd0);
        chk("rst_pc_ready",  {31'd0, pc_ready_o},  32'd0);
        chk("rst_dec_valid", {31'd0, dec_valid_o}, 32'd0);
        chk("rst_count",     {29'd0, count_o},     32'd0);
        chk("rst_dec_instr", dec_instr_o,          32'd0);
        chk("rst_dec_pc",    dec_pc_o,             32'd0);

        // ---- 1: steady stream ----
        rst_i = 1'b0;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_req0",      {31'd0, imem_req_o},  32'd1);
        chk("t1_ready0",    {31'd0, pc_ready_o},  32'd1);
        chk("t1_dv0",       {31'd0, dec_valid_o}, 32'd0);
        cyc();
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h11110000, 1'b0, 1'b1);
        chk("t1_count1",    {29'd0, count_o},     32'd1);
        chk("t1_dv1",       {31'd0, dec_valid_o}, 32'd0);
        cyc();
        drive(1'b1, 32'h8, 1'b1, 1'b1, 32'h11110004, 1'b0, 1'b1);
        chk("t1_dv2",       {31'd0, dec_valid_o}, 32'd1);
        chk("t1_pc2",       dec_pc_o,             32'h0);
        chk("t1_instr2",    dec_instr_o,          32'h11110000);
        chk("t1_count2",    {29'd0, count_o},     32'd2);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h11110008, 1'b0, 1'b1);
        chk("t1_pc3",       dec_pc_o,             32'h4);
        chk("t1_instr3",    dec_instr_o,          32'h11110004);
        chk("t1_count3",    {29'd0, count_o},     32'd2);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_pc4",       dec_pc_o,             32'h8);
        chk("t1_instr4",    dec_instr_o,          32'h11110008);
        chk("t1_count4",    {29'd0, count_o},     32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_dv_empty",  {31'd0, dec_valid_o}, 32'd0);
        chk("t1_count_end", {29'd0, count_o},     32'd0);

        // ---- 2: backpressure ----
        cyc();
        drive(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_g1", {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b1, 32'h24, 1'b1, 1'b1, 32'h22220020, 1'b0, 1'b0);
        chk("t2_g2", {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b1, 32'h28, 1'b1, 1'b1, 32'h22220024, 1'b0, 1'b0);
        chk("t2_g3", {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b1, 32'h2C, 1'b1, 1'b1, 32'h22220028, 1'b0, 1'b0);
        chk("t2_g4", {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b1, 32'h30, 1'b1, 1'b1, 32'h2222002C, 1'b0, 1'b0);
        chk("t2_full_count", {29'd0, count_o},    32'd4);
        chk("t2_full_req",   {31'd0, imem_req_o}, 32'd0);
        chk("t2_full_rdy",   {31'd0, pc_ready_o}, 32'd0);
        chk("t2_head_pc",    dec_pc_o,            32'h20);
        cyc();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_full_req2",  {31'd0, imem_req_o}, 32'd0);
        cyc();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_nobypass",   {31'd0, imem_req_o}, 32'd0);
        chk("t2_pop1_pc",    dec_pc_o,            32'h20);
        chk("t2_pop1_instr", dec_instr_o,         32'h22220020);
        cyc();
        drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_req_after",  {31'd0, pc_ready_o}, 32'd1);
        chk("t2_pop2_pc",    dec_pc_o,            32'h24);
        chk("t2_count_p2",   {29'd0, count_o},    32'd3);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h22220030, 1'b0, 1'b1);
        chk("t2_pop3_pc",    dec_pc_o,            32'h28);
        chk("t2_count_p3",   {29'd0, count_o},    32'd3);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pop4_instr", dec_instr_o,         32'h2222002C);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pop5_pc",    dec_pc_o,            32'h30);
        chk("t2_pop5_instr", dec_instr_o,         32'h22220030);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_empty",      {29'd0, count_o},    32'd0);

        // ---- 3: flush with two in flight ----
        cyc();
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc();
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("t3_flush_req", {31'd0, imem_req_o}, 32'd0);
        chk("t3_flush_rdy", {31'd0, pc_ready_o}, 32'd0);
        cyc();
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'hAAAA0001, 1'b0, 1'b1);
        chk("t3_count0",    {29'd0, count_o},    32'd0);
        chk("t3_req_new",   {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA0002, 1'b0, 1'b1);
        chk("t3_drop1_dv",  {31'd0, dec_valid_o}, 32'd0);
        chk("t3_count1",    {29'd0, count_o},     32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB0100, 1'b0, 1'b1);
        chk("t3_drop2_dv",  {31'd0, dec_valid_o}, 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_dv",        {31'd0, dec_valid_o}, 32'd1);
        chk("t3_pc",        dec_pc_o,             32'h100);
        chk("t3_instr",     dec_instr_o,          32'hBBBB0100);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_empty",     {29'd0, count_o},     32'd0);

        // ---- 4: flush with rvalid and pop in the same cycle ----
        cyc();
        drive(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h204, 1'b1, 1'b1, 32'hCCCC0200, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h208, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC0204, 1'b1, 1'b1);
        chk("t4_flush_dv",    {31'd0, dec_valid_o}, 32'd0);
        chk("t4_flush_instr", dec_instr_o,          32'd0);
        cyc();
        drive(1'b1, 32'h300, 1'b1, 1'b1, 32'hDEAD0208, 1'b0, 1'b1);
        chk("t4_count0",      {29'd0, count_o},     32'd0);
        chk("t4_dv0",         {31'd0, dec_valid_o}, 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hEEEE0300, 1'b0, 1'b1);
        chk("t4_drop_dv",     {31'd0, dec_valid_o}, 32'd0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_pc",          dec_pc_o,             32'h300);
        chk("t4_instr",       dec_instr_o,          32'hEEEE0300);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // ---- 6: misaligned PC ----
        cyc();
        drive(1'b1, 32'h103, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_addr", imem_addr_o, 32'h100);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t6_dec_pc",    dec_pc_o,    32'h103);
        chk("t6_dec_instr", dec_instr_o, 32'h12345678);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

        // ---- 5: asynchronous reset mid-stream ----
        cyc();
        drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h404, 1'b1, 1'b1, 32'h0F0F0400, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h408, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h40C, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("t5_pre_count", {29'd0, count_o},     32'd3);
        chk("t5_pre_dv",    {31'd0, dec_valid_o}, 32'd1);
        chk("t5_pre_req",   {31'd0, imem_req_o},  32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_async_dv",    {31'd0, dec_valid_o}, 32'd0);
        chk("t5_async_req",   {31'd0, imem_req_o},  32'd0);
        chk("t5_async_count", {29'd0, count_o},     32'd0);
        cyc();
        rst_i = 1'b0;
        drive(1'b1, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_post_count", {29'd0, count_o},    32'd0);
        chk("t5_post_rdy",   {31'd0, pc_ready_o}, 32'd1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h55550500, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_post_pc",    dec_pc_o,    32'h500);
        chk("t5_post_instr", dec_instr_o, 32'h55550500);
        cyc();

        $display("%0d/%0d checks passed", passes, checks + (fails - (checks - passes)));
        $finish;
    end

endmodule
